fp_fft_sched: RTL and testbench
===============================

FP_FFT_SCHED -- requirements
Module: fp_fft_sched

Interface
REQ-001 The block SHALL have parameter LOG2N, default 3, meaning log2 of FFT length N (range 1..15).
REQ-002 The block SHALL have parameter PIPE_LAT, default 2, meaning cycles from rd_en to the matching wr_en (1-cycle RAM read plus butterfly latency; minimum 1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin one in-place N-point radix-2 DIT pass.
REQ-006 The block SHALL have port stall, input, 1 bit: when high, suppresses new butterfly issue.
REQ-007 The block SHALL have port busy, output, 1 bit: a transform is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 The block SHALL have port rd_en, output, 1 bit: sample-RAM read strobe for both operands.
REQ-010 The block SHALL have ports rd_addr_a and rd_addr_b, outputs, LOG2N bits each: addresses of operands A and B.
REQ-011 The block SHALL have port tw_addr, output, LOG2N-1 bits (minimum 1): twiddle ROM index, issued with rd_en.
REQ-012 The block SHALL have port bfly_valid, output, 1 bit: rd_en delayed 1 cycle; drives butterfly valid_in.
REQ-013 The block SHALL have ports wr_en, wr_addr_a and wr_addr_b, outputs, 1/LOG2N/LOG2N bits: write-back of butterfly outputs C to wr_addr_a and D to wr_addr_b.
REQ-014 The block SHALL have port stage, output, 4 bits: current stage index.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-016 In IDLE, start=1 SHALL move the FSM to RUN, clearing stage and butterfly counter k; start in any other state SHALL be ignored.
REQ-017 In RUN with stall=0, the block SHALL assert rd_en with rd_addr_a = (k>>s)*2^(s+1) + (k & (2^s-1)), rd_addr_b = rd_addr_a + 2^s, tw_addr = (k & (2^s-1)) << (LOG2N-1-s), where s = stage, then increment k.
REQ-018 In RUN with stall=1, rd_en SHALL be 0 and k SHALL hold, while in-flight operations continue to retire.
REQ-019 After issuing k = N/2-1, the FSM SHALL enter DRAIN.
REQ-020 DRAIN SHALL persist until the last write of the stage has occurred; the next stage's first rd_en SHALL come in the cycle after that wr_en, with no read-after-write overlap between stages.
REQ-021 On leaving DRAIN, if stage < LOG2N-1 the block SHALL increment stage, clear k and return to RUN; otherwise it SHALL go to DONE.
REQ-022 wr_en, wr_addr_a and wr_addr_b SHALL equal rd_en, rd_addr_a and rd_addr_b delayed exactly PIPE_LAT cycles, implemented as a shift register independent of stall.
REQ-023 In DONE, done SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-024 busy SHALL be 1 in RUN, DRAIN and DONE, and 0 in IDLE.
REQ-025 The first rd_en SHALL occur in the cycle after start is sampled; done SHALL occur in the cycle after the final wr_en.
REQ-026 With no stall, the total span SHALL be LOG2N*(N/2 + PIPE_LAT) cycles from the first rd_en through the final wr_en.
REQ-027 Input ordering (bit reversal) SHALL be the loader's responsibility; the block SHALL perform no reordering.

Reset
REQ-028 When rst=1 the block SHALL force the FSM to IDLE, set stage and k to 0, clear the delay pipeline, and hold busy, done, rd_en, bfly_valid and wr_en at 0 in the following cycle.
REQ-029 Reset mid-transform SHALL abort it, with no wr_en thereafter, and the next start SHALL begin at stage 0.
REQ-030 Outputs SHALL be 0 while rst is asserted.

Verification
REQ-031 LOG2N=3, PIPE_LAT=2, start at cycle 0 -> stage 0 pairs (0,1),(2,3),(4,5),(6,7) with tw 0, on rd_en cycles 1-4; wr_en cycles 3-6.
REQ-032 Same run -> stage 1 pairs (0,2)tw0, (1,3)tw2, (4,6)tw0, (5,7)tw2 on cycles 7-10; stage 2 pairs (0,4)tw0, (1,5)tw1, (2,6)tw2, (3,7)tw3 on cycles 13-16; final wr_en at cycle 18; done at cycle 19; busy 1 over cycles 1-19.
REQ-033 stall=1 for 3 cycles during stage 1 -> rd_en gaps of 3 cycles, address sequence unchanged, done delayed by exactly 3 cycles, wr_en still exactly PIPE_LAT after each rd_en.
REQ-034 start pulsed again at cycle 9 -> ignored; outputs identical to REQ-031/032.
REQ-035 rst at cycle 8 -> from cycle 9 rd_en, wr_en and busy are 0; a new start yields the stage 0 sequence again.
REQ-036 LOG2N=1 -> single rd_en (0,1) with tw 0, one wr_en, then done.

Source files
------------

// File: rtl/fp_fft_sched_if.sv
// Control and sample-memory signals between the radix-2 FFT address scheduler
// (master) and the RAM/twiddle/butterfly datapath it sequences (slave).
interface fp_fft_sched_if #(
  parameter int LOG2N = 3
);
  localparam int TW_W = (LOG2N > 1) ? (LOG2N - 1) : 1;

  logic             start;
  logic             stall;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr_a;
  logic [LOG2N-1:0] rd_addr_b;
  logic [TW_W-1:0]  tw_addr;
  logic             bfly_valid;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr_a;
  logic [LOG2N-1:0] wr_addr_b;
  logic [3:0]       stage;

  modport master (
    input  start, stall,
    output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           bfly_valid, wr_en, wr_addr_a, wr_addr_b, stage
  );

  modport slave (
    output start, stall,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           bfly_valid, wr_en, wr_addr_a, wr_addr_b, stage
  );
endinterface

// File: rtl/fp_fft_sched.sv
// In-place radix-2 DIT FFT scheduler: walks stages and butterflies, issues RAM
// reads with twiddle index and replays the addresses PIPE_LAT cycles later as writes.
module fp_fft_sched #(
  parameter int LOG2N    = 3,
  parameter int PIPE_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  fp_fft_sched_if.master bus
);
  localparam int                  TW_W       = (LOG2N > 1) ? (LOG2N - 1) : 1;
  localparam logic [LOG2N-1:0]    K_LAST     = LOG2N'((2 ** (LOG2N - 1)) - 1);
  localparam logic [LOG2N-1:0]    K_ONE      = LOG2N'(1'b1);
  localparam logic [3:0]          STAGE_LAST = 4'(LOG2N - 1);
  localparam logic [PIPE_LAT-1:0] VLD_TOP    = PIPE_LAT'(1'b1) << (PIPE_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic [3:0]                     stage_q, stage_d;
  logic [LOG2N-1:0]               k_q, k_d;
  logic [PIPE_LAT-1:0]            vld_q, vld_d;
  logic [PIPE_LAT-1:0][LOG2N-1:0] pa_q, pa_d, pb_q, pb_d;
  logic                           bv_q, bv_d;
  logic                           issue_s, rd_en_s, done_s, last_wr_s;
  logic [LOG2N-1:0]               mask_s, low_s, addr_a_s, addr_b_s;
  logic [TW_W-1:0]                tw_s;

  // Only the final write of the stage is left in flight when the top slot alone is valid.
  assign last_wr_s = (vld_q == VLD_TOP);
  assign rd_en_s   = issue_s & ~rst;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    issue_s = 1'b0;
    done_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          stage_d = 4'd0;
          k_d     = {LOG2N{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!bus.stall) begin
          issue_s = 1'b1;
          if (k_q == K_LAST) begin
            state_d = DRAIN;
          end else begin
            k_d = k_q + K_ONE;
          end
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (last_wr_s) begin
          if (stage_q == STAGE_LAST) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            stage_d = stage_q + 4'd1;
            k_d     = {LOG2N{1'b0}};
          end
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        done_s  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Butterfly k of stage s pairs (k>>s)*2^(s+1) + (k mod 2^s) with the element 2^s above it.
  always_comb begin
    mask_s   = (K_ONE << stage_q) - K_ONE;
    low_s    = k_q & mask_s;
    addr_a_s = ((k_q >> stage_q) << (stage_q + 4'd1)) | low_s;
    addr_b_s = addr_a_s | (K_ONE << stage_q);
    tw_s     = TW_W'(low_s << (STAGE_LAST - stage_q));
  end

  always_comb begin
    bv_d     = rd_en_s;
    vld_d    = vld_q;
    pa_d     = pa_q;
    pb_d     = pb_q;
    vld_d[0] = rd_en_s;
    pa_d[0]  = addr_a_s;
    pb_d[0]  = addr_b_s;
    for (int i = 1; i < PIPE_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      pa_d[i]  = pa_q[i-1];
      pb_d[i]  = pb_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      stage_q <= 4'd0;
      k_q     <= {LOG2N{1'b0}};
      vld_q   <= {PIPE_LAT{1'b0}};
      pa_q    <= {(PIPE_LAT*LOG2N){1'b0}};
      pb_q    <= {(PIPE_LAT*LOG2N){1'b0}};
      bv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      vld_q   <= vld_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      bv_q    <= bv_d;
    end
  end

  // Every output is forced low while rst is high, even before the state flops clear.
  assign bus.busy       = ~rst & (state_q != IDLE);
  assign bus.done       = ~rst & done_s;
  assign bus.rd_en      = rd_en_s;
  assign bus.rd_addr_a  = rst ? {LOG2N{1'b0}} : addr_a_s;
  assign bus.rd_addr_b  = rst ? {LOG2N{1'b0}} : addr_b_s;
  assign bus.tw_addr    = rst ? {TW_W{1'b0}} : tw_s;
  assign bus.bfly_valid = ~rst & bv_q;
  assign bus.wr_en      = ~rst & vld_q[PIPE_LAT-1];
  assign bus.wr_addr_a  = rst ? {LOG2N{1'b0}} : pa_q[PIPE_LAT-1];
  assign bus.wr_addr_b  = rst ? {LOG2N{1'b0}} : pb_q[PIPE_LAT-1];
  assign bus.stage      = rst ? 4'd0 : stage_q;
endmodule

// File: tb/tb_fp_fft_sched.sv
// Directed bench for fp_fft_sched: an 8-point schedule (plain, stalled, repeated
// start, mid-run reset) plus a 2-point instance, against hand-written tables.
module tb_fp_fft_sched;
  localparam int NC = 48;

  logic clk;
  logic rst;

  fp_fft_sched_if #(.LOG2N(3)) bus3 ();
  fp_fft_sched_if #(.LOG2N(1)) bus1 ();

  fp_fft_sched #(.LOG2N(3), .PIPE_LAT(2)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));
  fp_fft_sched #(.LOG2N(1), .PIPE_LAT(2)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Hand-derived 8-point schedule when start is sampled in cycle 0.
  localparam int EXP_CYC [12] = '{1, 2, 3, 4, 7, 8, 9, 10, 13, 14, 15, 16};
  localparam int EXP_A   [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  localparam int EXP_B   [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  localparam int EXP_TW  [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  int   n_total = 0;
  int   n_bad   = 0;
  logic start_v [NC];
  logic stall_v [NC];
  logic rst_v   [NC];
  int   rd_t [NC], ra_t [NC], rb_t [NC], tw_t [NC], wr_t [NC], wa_t [NC], wb_t [NC];
  int   bv_t [NC], busy_t [NC], done_t [NC], stage_t [NC];
  int   rd1_t [NC], ra1_t [NC], rb1_t [NC], tw1_t [NC], wr1_t [NC], wa1_t [NC], wb1_t [NC];
  int   busy1_t [NC], done1_t [NC];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stim();
    for (int c = 0; c < NC; c++) begin
      start_v[c] = 1'b0;
      stall_v[c] = 1'b0;
      rst_v[c]   = 1'b0;
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus3.start = 1'b0; bus3.stall = 1'b0;
    bus1.start = 1'b0; bus1.stall = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    #3;
    chk({tag, " busy in rst"}, bus3.busy, 0);
    chk({tag, " rd_en in rst"}, bus3.rd_en, 0);
    rst = 1'b0;
    #1;
    chk({tag, " busy after rst"}, bus3.busy, 0);
    chk({tag, " done after rst"}, bus3.done, 0);
    chk({tag, " wr_en after rst"}, bus3.wr_en, 0);
    chk({tag, " bfly_valid after rst"}, bus3.bfly_valid, 0);
    chk({tag, " stage after rst"}, bus3.stage, 0);
    @(posedge clk); #1;
  endtask

  // Inputs for cycle c are applied just after the edge that opens it; outputs sampled mid-cycle.
  task automatic run_seq(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      rst = rst_v[c];
      bus3.start = start_v[c]; bus3.stall = stall_v[c];
      bus1.start = start_v[c]; bus1.stall = stall_v[c];
      #3;
      rd_t[c] = bus3.rd_en;   ra_t[c] = bus3.rd_addr_a; rb_t[c] = bus3.rd_addr_b;
      tw_t[c] = bus3.tw_addr; wr_t[c] = bus3.wr_en;     wa_t[c] = bus3.wr_addr_a;
      wb_t[c] = bus3.wr_addr_b; bv_t[c] = bus3.bfly_valid; busy_t[c] = bus3.busy;
      done_t[c] = bus3.done;  stage_t[c] = bus3.stage;
      rd1_t[c] = bus1.rd_en;  ra1_t[c] = bus1.rd_addr_a; rb1_t[c] = bus1.rd_addr_b;
      tw1_t[c] = bus1.tw_addr; wr1_t[c] = bus1.wr_en;    wa1_t[c] = bus1.wr_addr_a;
      wb1_t[c] = bus1.wr_addr_b; busy1_t[c] = bus1.busy; done1_t[c] = bus1.done;
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  // Table entry issued in cycle c; entries from index sf onward are delayed by sb cycles.
  function automatic int rd_idx(input int c, input int off, input int sf, input int sb);
    int r = -1;
    for (int i = 0; i < 12; i++) begin
      if (EXP_CYC[i] + off + ((i >= sf) ? sb : 0) == c) r = i;
    end
    return r;
  endfunction

  task automatic verify_run(input string tag, input int off, input int sf, input int sb,
                            input int lo, input int hi);
    int dc = off + 19 + sb;
    for (int c = lo; c <= hi; c++) begin
      int ir = rd_idx(c, off, sf, sb);
      int iw = rd_idx(c - 2, off, sf, sb);
      int iv = rd_idx(c - 1, off, sf, sb);
      chk($sformatf("%s rd_en c%0d", tag, c), rd_t[c], int'(ir >= 0));
      if (ir >= 0) begin
        chk($sformatf("%s rd_addr_a c%0d", tag, c), ra_t[c], EXP_A[ir]);
        chk($sformatf("%s rd_addr_b c%0d", tag, c), rb_t[c], EXP_B[ir]);
        chk($sformatf("%s tw_addr c%0d", tag, c), tw_t[c], EXP_TW[ir]);
        chk($sformatf("%s stage c%0d", tag, c), stage_t[c], ir / 4);
      end
      chk($sformatf("%s wr_en c%0d", tag, c), wr_t[c], int'(iw >= 0));
      if (iw >= 0) begin
        chk($sformatf("%s wr_addr_a c%0d", tag, c), wa_t[c], EXP_A[iw]);
        chk($sformatf("%s wr_addr_b c%0d", tag, c), wb_t[c], EXP_B[iw]);
      end
      chk($sformatf("%s bfly_valid c%0d", tag, c), bv_t[c], int'(iv >= 0));
      chk($sformatf("%s busy c%0d", tag, c), busy_t[c], int'(c >= off + 1 && c <= dc));
      chk($sformatf("%s done c%0d", tag, c), done_t[c], int'(c == dc));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus3.start = 1'b0; bus3.stall = 1'b0;
    bus1.start = 1'b0; bus1.stall = 1'b0;
    @(posedge clk); #1;

    // Plain 8-point pass, with the 2-point instance started alongside it.
    do_reset("base");
    clear_stim();
    start_v[0] = 1'b1;
    run_seq(30);
    verify_run("base", 0, 12, 0, 0, 29);
    for (int c = 0; c < 9; c++) begin
      chk($sformatf("n2 rd_en c%0d", c), rd1_t[c], int'(c == 1));
      chk($sformatf("n2 wr_en c%0d", c), wr1_t[c], int'(c == 3));
      chk($sformatf("n2 busy c%0d", c), busy1_t[c], int'(c >= 1 && c <= 4));
      chk($sformatf("n2 done c%0d", c), done1_t[c], int'(c == 4));
    end
    chk("n2 rd_addr_a", ra1_t[1], 0);
    chk("n2 rd_addr_b", rb1_t[1], 1);
    chk("n2 tw_addr", tw1_t[1], 0);
    chk("n2 wr_addr_a", wa1_t[3], 0);
    chk("n2 wr_addr_b", wb1_t[3], 1);

    // Three stalled cycles in stage 1 push the rest of the schedule out by three.
    do_reset("stall");
    clear_stim();
    start_v[0] = 1'b1;
    stall_v[8] = 1'b1; stall_v[9] = 1'b1; stall_v[10] = 1'b1;
    run_seq(32);
    verify_run("stall", 0, 5, 3, 0, 31);

    // start while RUN, DRAIN and DONE must leave the schedule untouched.
    do_reset("restart");
    clear_stim();
    start_v[0] = 1'b1; start_v[5] = 1'b1; start_v[9] = 1'b1; start_v[19] = 1'b1;
    run_seq(30);
    verify_run("restart", 0, 12, 0, 0, 29);

    // Reset in cycle 8 aborts stage 1; a fresh start in cycle 12 begins again at stage 0.
    do_reset("midrst");
    clear_stim();
    start_v[0] = 1'b1; rst_v[8] = 1'b1; start_v[12] = 1'b1;
    run_seq(40);
    verify_run("midrst pre", 0, 12, 0, 0, 7);
    for (int c = 8; c < 13; c++) begin
      chk($sformatf("midrst rd_en c%0d", c), rd_t[c], 0);
      chk($sformatf("midrst wr_en c%0d", c), wr_t[c], 0);
      chk($sformatf("midrst busy c%0d", c), busy_t[c], 0);
      chk($sformatf("midrst bfly_valid c%0d", c), bv_t[c], 0);
      chk($sformatf("midrst stage c%0d", c), stage_t[c], 0);
    end
    verify_run("midrst post", 12, 12, 0, 13, 39);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
